rst_seq_core: RTL and testbench

//  Core-domain reset sequencer; sits downstream of the Nexys A7 clock

---
 rtl/rst_seq_core.sv | 168 ++++++++++++++++
 tb/tb_rst_seq_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_core.sv
// rtl/rst_seq_core.sv - core-domain staged reset sequencer driven by PLL lock
// Optional software reset hold (i_sw_rst, SWRST state): define RST_SEQ_SWRST_EN
module rst_seq_core #(
  parameter int NUM_STAGES         = 3,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int STAGE_GAP_CYCLES   = 8,
  parameter int SW_RST_CYCLES      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_locked,
`ifdef RST_SEQ_SWRST_EN
  input  logic                  i_sw_rst,
`endif
  output logic [NUM_STAGES-1:0] o_rst_stage,
  output logic                  o_rst_done
);

  localparam int MAX_LG  = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int MAX_CNT = (MAX_LG > SW_RST_CYCLES) ? MAX_LG : SW_RST_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int KW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // The RELEASE cycle itself counts toward each gap, hence the -2 terminal counts.
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((STAGE_GAP_CYCLES >= 2) ? STAGE_GAP_CYCLES - 2 : 0);
`ifdef RST_SEQ_SWRST_EN
  localparam logic [CW-1:0] SW_LAST   = CW'((SW_RST_CYCLES >= 2) ? SW_RST_CYCLES - 2 : 0);
`endif
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [KW-1:0] LAST_K    = KW'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
    $error("rst_seq_core: NUM_STAGES must be 1..8");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_lock_cycles
    $error("rst_seq_core: LOCK_STABLE_CYCLES must be >= 1");
  end
  if (STAGE_GAP_CYCLES < 1) begin : g_bad_gap_cycles
    $error("rst_seq_core: STAGE_GAP_CYCLES must be >= 1");
  end
  if (SW_RST_CYCLES < 1) begin : g_bad_sw_cycles
    $error("rst_seq_core: SW_RST_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_HOLD, S_WAIT_LOCK, S_RELEASE, S_GAP, S_RUN, S_SWRST
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [KW-1:0]           k_q, k_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;
  logic [1:0]              rst_sync_q, rst_sync_d;
  logic [1:0]              lock_sync_q, lock_sync_d;
  logic                    rst_s, lock_s;

  assign rst_s   = rst_sync_q[1];
  assign lock_s  = lock_sync_q[1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b0};
    lock_sync_d = {lock_sync_q[0], i_locked};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    stage_d = stage_q;
    done_d  = done_q;
    case (state_q)
      S_HOLD: begin
        if (!rst_s) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_RELEASE;
          k_d     = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RELEASE: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (KW'(i) == k_q) stage_d[i] = 1'b0;
        end
        cnt_d = '0;
        if (k_q == LAST_K) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else if (STAGE_GAP_CYCLES == 1) begin
          k_d = k_q + KW'(1);
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          k_d     = k_q + KW'(1);
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
`ifdef RST_SEQ_SWRST_EN
        if (i_sw_rst) begin
          stage_d = '1;
          done_d  = 1'b0;
          cnt_d   = '0;
          k_d     = '0;
          state_d = (SW_RST_CYCLES == 1) ? S_RELEASE : S_SWRST;
        end
`endif
      end
`ifdef RST_SEQ_SWRST_EN
      S_SWRST: begin
        if (cnt_q == SW_LAST) begin
          state_d = S_RELEASE;
          k_d     = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      default: state_d = S_HOLD;
    endcase
    // Lock loss beats everything once any stage may be running.
    if (!lock_s && (state_q inside {S_RELEASE, S_GAP, S_RUN, S_SWRST})) begin
      state_d = S_WAIT_LOCK;
      stage_d = '1;
      done_d  = 1'b0;
      cnt_d   = '0;
      k_d     = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_sync_q  <= 2'b11;
      lock_sync_q <= 2'b00;
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      k_q         <= '0;
      stage_q     <= '1;
      done_q      <= 1'b0;
    end else begin
      rst_sync_q  <= rst_sync_d;
      lock_sync_q <= lock_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      done_q      <= done_d;
    end
  end

  assign o_rst_stage = stage_q;
  assign o_rst_done  = done_q;

endmodule

// File: tb/tb_rst_seq_core.sv
// tb/tb_rst_seq_core.sv - self-checking bench for rst_seq_core
// Software-reset scenario compiled in only with RST_SEQ_SWRST_EN
module tb_rst_seq_core;

  localparam int N = 3;
  localparam int L = 16;
  localparam int G = 8;
  localparam int S = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         locked = 1'b1;
  logic         sw = 1'b0;
  logic [N-1:0] o_rst_stage;
  logic         o_rst_done;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  rst_seq_core #(
    .NUM_STAGES(N), .LOCK_STABLE_CYCLES(L), .STAGE_GAP_CYCLES(G), .SW_RST_CYCLES(S)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_locked(locked),
`ifdef RST_SEQ_SWRST_EN
    .i_sw_rst(sw),
`endif
    .o_rst_stage(o_rst_stage),
    .o_rst_done(o_rst_done)
  );

  // Timeline model: m_t counts edges since the first stable-lock edge (T0);
  // stage k is released once m_t >= L + k*G.
  logic       m_hold = 1'b1;
  logic [1:0] m_rsync = 2'b11;
  logic [1:0] m_lsync = 2'b00;
  logic       m_valid = 1'b0;
  int         m_t = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold  <= 1'b1;
      m_rsync <= 2'b11;
      m_lsync <= 2'b00;
      m_valid <= 1'b0;
      m_t     <= 0;
    end else begin
      m_rsync <= {m_rsync[0], 1'b0};
      m_lsync <= {m_lsync[0], locked};
      if (m_hold) begin
        if (!m_rsync[1]) m_hold <= 1'b0;
      end else if (!m_lsync[1]) begin
        m_valid <= 1'b0;
      end else if (!m_valid) begin
        m_valid <= 1'b1;
        m_t     <= 0;
`ifdef RST_SEQ_SWRST_EN
      end else if (sw && m_t >= L + (N - 1) * G) begin
        m_t <= L - S;
`endif
      end else if (m_t < 1000000) begin
        m_t <= m_t + 1;
      end
    end
  end

  function automatic logic [N-1:0] exp_stage(input logic v, input int t);
    logic [N-1:0] r;
    r = '1;
    for (int k = 0; k < N; k++) if (v && t >= L + k * G) r[k] = 1'b0;
    return r;
  endfunction

  function automatic logic exp_done(input logic v, input int t);
    return v && (t >= L + (N - 1) * G);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (o_rst_stage !== exp_stage(m_valid, m_t)) begin
        errors++;
        $display("FAIL model_stage t=%0t got=%b exp=%b", $time, o_rst_stage, exp_stage(m_valid, m_t));
      end
      checks++;
      if (o_rst_done !== exp_done(m_valid, m_t)) begin
        errors++;
        $display("FAIL model_done t=%0t got=%b exp=%b", $time, o_rst_done, exp_done(m_valid, m_t));
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    mon_en = 1'b1;
    chk("reset_stage", 8'(o_rst_stage), 8'b111);
    chk("reset_done", 8'(o_rst_done), 8'd0);

    // Steady lock: releases at T0+16/+24/+32, T0 is the 4th edge after release
    rst = 1'b0;
    tick(19); chk("t1_pre_s0", 8'(o_rst_stage), 8'b111);
    tick(1);  chk("t1_s0", 8'(o_rst_stage), 8'b110);
    tick(7);  chk("t1_pre_s1", 8'(o_rst_stage), 8'b110);
    tick(1);  chk("t1_s1", 8'(o_rst_stage), 8'b100);
    tick(7);  chk("t1_pre_s2", 8'(o_rst_stage), 8'b100);
              chk("t1_pre_done", 8'(o_rst_done), 8'd0);
    tick(1);  chk("t1_s2", 8'(o_rst_stage), 8'b000);
              chk("t1_done", 8'(o_rst_done), 8'd1);
    tick(5);

    // Late lock, 40 cycles after reset release
    rst = 1'b1; locked = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(40);
    chk("t2_no_lock", 8'(o_rst_stage), 8'b111);
    locked = 1'b1;
    tick(18); chk("t2_pre_s0", 8'(o_rst_stage), 8'b111);
    tick(1);  chk("t2_s0", 8'(o_rst_stage), 8'b110);
    tick(17); chk("t2_done", 8'(o_rst_done), 8'd1);

    // Lock loss in RUN for 5 cycles
    locked = 1'b0;
    tick(2);  chk("t4_still_run", 8'(o_rst_stage), 8'b000);
    tick(1);  chk("t4_assert", 8'(o_rst_stage), 8'b111);
              chk("t4_done_low", 8'(o_rst_done), 8'd0);
    tick(2);
    locked = 1'b1;
    tick(18); chk("t4_pre_s0", 8'(o_rst_stage), 8'b111);
    tick(1);  chk("t4_s0", 8'(o_rst_stage), 8'b110);
    tick(20); chk("t4_done", 8'(o_rst_done), 8'd1);

    // One-cycle lock glitch at count 10 restarts the stable count
    locked = 1'b0;
    tick(6);
    locked = 1'b1;
    tick(12);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(6);  chk("t3_no_early", 8'(o_rst_stage), 8'b111);
    tick(12); chk("t3_pre_s0", 8'(o_rst_stage), 8'b111);
    tick(1);  chk("t3_s0", 8'(o_rst_stage), 8'b110);
    tick(30); chk("t3_done", 8'(o_rst_done), 8'd1);

    // Async reset mid-GAP
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(23); chk("t5_in_gap", 8'(o_rst_stage), 8'b110);
    rst = 1'b1;
    #1;
    chk("t5_async_stage", 8'(o_rst_stage), 8'b111);
    chk("t5_async_done", 8'(o_rst_done), 8'd0);
    tick(1);
    rst = 1'b0;
    tick(19); chk("t5_pre_s0", 8'(o_rst_stage), 8'b111);
    tick(1);  chk("t5_s0", 8'(o_rst_stage), 8'b110);
    tick(16); chk("t5_s2", 8'(o_rst_stage), 8'b000);
              chk("t5_done", 8'(o_rst_done), 8'd1);

`ifdef RST_SEQ_SWRST_EN
    // Software reset pulse in RUN, then a pulse during GAP that must be ignored
    tick(3);
    sw = 1'b1;
    tick(1);
    sw = 1'b0;
    chk("t6_assert", 8'(o_rst_stage), 8'b111);
    chk("t6_done_low", 8'(o_rst_done), 8'd0);
    tick(31); chk("t6_pre_s0", 8'(o_rst_stage), 8'b111);
    tick(1);  chk("t6_s0", 8'(o_rst_stage), 8'b110);
    tick(3);
    sw = 1'b1;
    tick(1);
    sw = 1'b0;
    chk("t6_gap_ignored", 8'(o_rst_stage), 8'b110);
    tick(4);  chk("t6_s1", 8'(o_rst_stage), 8'b100);
    tick(8);  chk("t6_s2", 8'(o_rst_stage), 8'b000);
              chk("t6_done", 8'(o_rst_done), 8'd1);
`endif

    tick(4);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
